serial_pattern_tx: RTL
======================

Name: serial_pattern_tx

Overview:
Serial bit-pattern transmitter: the generator side of the serial sequence-detector FSM. It takes a parallel pattern plus a length and repeat count, then drives the bits MSB-first onto a 1-bit serial line, one bit per clock. It is a Moore-style controller with a shift register and counters. Its `out`/`valid` pair feeds the `in` input of the detector FSMs in the same design.

Parameters:
WIDTH, 8, maximum pattern length in bits (pattern register width).
LEN_W, 4, width of the `len` input; must satisfy 2^LEN_W > WIDTH.
REP_W, 4, width of the `repeat_cnt` input.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  request to transmit; sampled only in IDLE.
pattern  input  WIDTH  bits to send; bit len-1 goes first, bit 0 goes last.
len  input  LEN_W  number of bits per frame; 0 = empty frame; values above WIDTH are clamped to WIDTH.
repeat_cnt  input  REP_W  extra repetitions; total frames sent = repeat_cnt+1.
out  output  1  serial data bit.
valid  output  1  high while `out` carries a pattern bit.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out=0, valid=0, busy=0, done=0; all internal registers cleared. Takes effect immediately, including mid-frame. No done pulse is issued for an aborted transfer.
- States: IDLE, SHIFT, DONE. Registered Moore outputs. Internally the block holds:
  - a latched pattern, a shift register and an effective length Leff=min(len,WIDTH);
  - a bit counter and a repeat counter.
- IDLE: out=0, valid=0, busy=0.
  - On start=1, latch pattern, Leff and repeat_cnt.
  - If Leff>=1, go to SHIFT; if Leff=0, go to DONE.
  - Latency: the first bit appears on `out` the cycle after start is sampled.
- SHIFT: valid=1, busy=1, out = current bit, starting at pattern[Leff-1] and moving down to pattern[0].
  - Each cycle, advance one bit and decrement the bit counter.
  - After the last bit of a frame with repeats remaining, reload from the latched copy and decrement the repeat counter. The next frame's first bit follows on the very next cycle, with no gap.
  - After the last bit of the final frame, go to DONE.
- DONE: held for exactly one cycle. done=1, busy=1, valid=0, out=0. Then return to IDLE.
- Frame count: exactly (repeat_cnt+1)*Leff cycles with valid=1 between start and done. done is asserted on the cycle after the last valid bit.
- start while busy: ignored. Pattern, len and repeat_cnt changes during a transfer have no effect.
- start held high continuously: a new transfer begins on the first IDLE cycle after DONE. This gives back-to-back transfers with one idle cycle between them.
- Counter widths: the bit counter is LEN_W bits and the repeat counter is REP_W bits, both down-counting with no wrap. repeat_cnt = 2^REP_W-1 is valid and yields 2^REP_W frames.

Test Plan:
- Reset 0 for 10 ns, then 1, idle 3 cycles -> out=0, valid=0, busy=0, done=0 throughout.
- pattern=8'h09, len=4, repeat=0, start pulse -> out=1,0,0,1 on cycles 1-4 with valid=1; done=1 on cycle 5; IDLE on cycle 6. A detector on the stream fires at the expected bit.
- pattern=8'hA5, len=12 (clamped to 8), repeat=1 -> 16 valid cycles: 10100101 10100101 with no gap; done on cycle 17.
- len=0, start -> no valid cycles; done on cycle 1; IDLE on cycle 2.
- start re-pulsed mid-frame with a different pattern -> output unchanged from the original frame. Reset driven low at bit 3 -> out/valid/busy drop to 0 immediately; no done pulse.
- start held high, pattern=8'h03, len=2 -> 1,1,DONE,IDLE,1,1,DONE... repeating with a period of 4 cycles.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends a parallel pattern MSB-first on a 1-bit line.
// The frame is repeated repeat_cnt+1 times with no gap between frames.
// The transfer ends with a single-cycle DONE state that pulses `done`.
// All outputs are registered, Moore style.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active low
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;     // current bit is always at the MSB
  logic [WIDTH-1:0] pat_q, pat_d;         // latched frame, MSB-aligned, reused for repeats
  logic [LEN_W-1:0] leff_q, leff_d;       // effective frame length
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d; // bits still to send after the current one
  logic [REP_W-1:0] rep_q, rep_d;         // frames still to send after the current one
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] leff_in;
  logic [WIDTH-1:0] aligned_in;

  // Clamp the requested length and left-align the pattern so that bit leff-1
  // sits at the MSB; bits above leff-1 fall off the top of the shift.
  always_comb begin
    leff_in    = (len > LEN_MAX) ? LEN_MAX : len;
    aligned_in = pattern << (WIDTH - int'(leff_in));
  end

  // Next-state and next-output logic for the IDLE/SHIFT/DONE controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    leff_d    = leff_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d  = aligned_in;
          leff_d = leff_in;
          rep_d  = repeat_cnt;
          if (leff_in != '0) begin
            // First bit goes out on the cycle right after start is sampled.
            state_d   = ST_SHIFT;
            shreg_d   = aligned_in;
            bit_cnt_d = leff_in - LEN_ONE;
            out_d     = aligned_in[WIDTH-1];
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end else begin
            // Empty frame: skip straight to the completion pulse.
            state_d = ST_DONE;
            busy_d  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q != '0) begin
          // More bits in this frame: move the next bit up to the MSB.
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - LEN_ONE;
          out_d     = shreg_q[WIDTH-2];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else if (rep_q != '0) begin
          // Frame finished with repeats left: reload with no gap cycle.
          shreg_d   = pat_q;
          bit_cnt_d = leff_q - LEN_ONE;
          rep_d     = rep_q - REP_ONE;
          out_d     = pat_q[WIDTH-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          // Last bit of the last frame has been shown.
          state_d = ST_DONE;
          shreg_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        // Outputs drop to their idle defaults; start is not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any transfer at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      leff_q    <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values of the previous cycle, independent of statement order.
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      leff_q    <= leff_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
